// File: rtl/arbiter_out_fifo.sv
// arbiter_out_fifo: first-word-fall-through output FIFO behind the arbiter tree.
// ready_out and valid_out come from the occupancy count only, so no
// combinational path runs through the FIFO in either direction.
module arbiter_out_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       ready_out,
  output logic                       valid_out,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_COUNT = CW'(AFULL_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Flags are derived from the registered count only.
  always_comb begin
    ready_out   = (count != FULL_COUNT);
    valid_out   = (count != '0);
    almost_full = (count >= AFULL_COUNT);
    push        = valid_in && ready_out;
    pop         = valid_out && ready_in;
    data_out    = mem[rd_ptr];
  end

  // Storage array; contents are not reset, and a stale entry is never shown because valid_out follows count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks the net push/pop balance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_arbiter_out_fifo.sv
// tb_arbiter_out_fifo: randomized and directed checks of arbiter_out_fifo
// against a queue-based reference model of an ordered bounded buffer.
module tb_arbiter_out_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic             clk;
  logic             rst;
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             ready_out;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             ready_in;
  logic [3:0]       count;
  logic             almost_full;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q[$];
  logic             popped;
  logic [WIDTH-1:0] popped_data;
  logic             pushed;

  arbiter_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_out   (ready_out),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .ready_in    (ready_in),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every visible output against what the model says the buffer holds.
  task automatic checkModel();
    int n;
    n = model_q.size();
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("valid_out", 32'(valid_out), 32'(n != 0));
    checkOutput("ready_out", 32'(ready_out), 32'(n != DEPTH));
    checkOutput("almost_full", 32'(almost_full), 32'(n >= AFULL));
    if (n != 0) checkOutput("data_out", 32'(data_out), 32'(model_q[0]));
  endtask

  // One clock cycle: drive inputs while clk is low, check, then apply the edge to the model.
  task automatic applyStimulus(input logic vin, input logic [WIDTH-1:0] din, input logic rin);
    logic do_push;
    logic do_pop;
    valid_in = vin;
    data_in  = din;
    ready_in = rin;
    #1;
    checkModel();
    do_push = vin && (model_q.size() < DEPTH);
    do_pop  = rin && (model_q.size() > 0);
    @(posedge clk);
    popped = do_pop;
    pushed = do_push;
    if (do_pop) popped_data = model_q.pop_front();
    if (do_push) model_q.push_back(din);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int received;
    int cycles;
    int max_count;
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    ready_in = 1'b0;
    popped   = 1'b0;
    pushed   = 1'b0;
    popped_data = '0;

    // Reset state while held in reset
    #3;
    checkModel();
    #9 rst = 1'b1;
    @(negedge clk);

    // Single word through an empty FIFO
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("single_valid", 32'(valid_out), 32'd1);
    checkOutput("single_data", 32'(data_out), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("single_popped", 32'(popped_data), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Fill to full with 0x01..0x08, then attempt a ninth push
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("full_ready", 32'(ready_out), 32'd0);
    applyStimulus(1'b1, 8'h99, 1'b0);
    checkOutput("ninth_refused", 32'(pushed), 32'd0);
    checkOutput("full_count", 32'(count), 32'd8);

    // From full, push and pop together: first cycle pops only
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h09 + i), 1'b1);
      checkOutput("full_order", 32'(popped_data), 32'(i + 1));
      checkOutput("full_sim_count", 32'(count), 32'd7);
    end
    while (model_q.size() != 0) applyStimulus(1'b0, 8'h00, 1'b1);

    // Wrap-around stream of 20 words with random consumer stalls
    sent = 0;
    received = 0;
    cycles = 0;
    max_count = 0;
    while (received < 20 && cycles < 400) begin
      applyStimulus(sent < 20, 8'(sent), 1'($urandom_range(0, 1)));
      if (pushed) sent++;
      if (popped) begin
        checkOutput("stream_order", 32'(popped_data), 32'(received));
        received++;
      end
      if (int'(count) > max_count) max_count = int'(count);
      cycles++;
    end
    checkOutput("stream_done", 32'(received), 32'd20);
    checkOutput("stream_bound", 32'(max_count <= DEPTH), 32'd1);

    // Asynchronous reset mid-operation with five words stored
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    checkOutput("pre_reset_count", 32'(count), 32'd5);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    checkOutput("async_count", 32'(count), 32'd0);
    checkOutput("async_valid", 32'(valid_out), 32'd0);
    checkOutput("async_ready", 32'(ready_out), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("post_reset_data", 32'(data_out), 32'h3C);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_reset_first", 32'(popped_data), 32'h3C);

    // Back-to-back streaming with an always-ready consumer
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
      checkOutput("b2b_count", 32'(count <= 1), 32'd1);
    end
    while (model_q.size() != 0) applyStimulus(1'b0, 8'h00, 1'b1);

    // Free-running random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 1 : $urandom_range(0, 1)));
    end
    checkModel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_out_fifo.md
ARBITER_OUT_FIFO -- requirements
Module: arbiter_out_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of storage entries; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have parameter AFULL_LEVEL, default 6, giving the almost_full threshold in entries; legal range is 1 to DEPTH.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 Port valid_in, input, 1 bit: upstream word valid; driven by the arbiter tree valid_out.
REQ-008 Port data_in, input, WIDTH bits: upstream word; driven by the arbiter tree data_out.
REQ-009 Port ready_out, output, 1 bit: FIFO can accept a word; drives the arbiter tree ready_in.
REQ-010 Port valid_out, output, 1 bit: head word valid toward the consumer.
REQ-011 Port data_out, output, WIDTH bits: head word toward the consumer.
REQ-012 Port ready_in, input, 1 bit: consumer accepts the head word.
REQ-013 Port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0 to DEPTH.
REQ-014 Port almost_full, output, 1 bit: high when count is AFULL_LEVEL or more.

Function
REQ-015 A push SHALL occur on a rising clk edge when valid_in and ready_out are both high; data_in is written at the write pointer.
REQ-016 A pop SHALL occur on a rising clk edge when valid_out and ready_in are both high; the read pointer advances.
REQ-017 ready_out SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on ready_in or valid_in.
REQ-018 valid_out SHALL equal (count != 0) and SHALL NOT depend combinationally on valid_in.
REQ-019 The FIFO SHALL be first-word-fall-through: data_out is the entry at the read pointer whenever valid_out is high.
REQ-020 When valid_out is low, data_out is don't-care.
REQ-021 Latency: a word pushed into an empty FIFO SHALL appear on data_out, with valid_out high, in the cycle after the push edge.
REQ-022 There SHALL be no combinational path from data_in to data_out.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-024 count SHALL change by +1 on push only, by -1 on pop only, and by 0 on simultaneous push and pop.
REQ-025 Simultaneous push and pop with count strictly between 0 and DEPTH SHALL both complete in the same cycle.
REQ-026 When full, ready_out is low, so a push in the same cycle as a pop is refused; the freed slot is offered in the next cycle.
REQ-027 When empty, valid_out is low, so no pop occurs; a same-cycle push is accepted.
REQ-028 While ready_out is low, data_in SHALL be ignored.
REQ-029 While valid_out is low, ready_in SHALL be ignored.
REQ-030 Words SHALL leave in exact arrival order, with no loss and no duplication.
REQ-031 Storage SHALL be a register array; storage contents need not be reset.

Reset
REQ-032 On rst low, asynchronously: both pointers 0, count 0, valid_out 0, ready_out 1, almost_full 0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words, and no stale word SHALL be presented after release.
REQ-034 The first push SHALL be accepted at the first rising clk edge after rst goes high.

Verification
REQ-035 Reset then single word: push 0xA5 with ready_in=0 -> next cycle valid_out=1, data_out=0xA5, count=1; then ready_in=1 -> count=0, valid_out=0.
REQ-036 Fill to full (DEPTH=8), pushes 0x01..0x08 with ready_in=0:
- almost_full rises when count reaches 6;
- ready_out=0 at count=8;
- a 9th valid_in is not accepted.
REQ-037 Full plus simultaneous traffic: from full, hold valid_in=1 and ready_in=1 -> first cycle pop only (count 7), then push and pop each cycle (count stays 7); output order 0x01, 0x02, ...
REQ-038 Wrap-around: stream 20 sequential words while ready_in toggles at random -> output sequence 0..19 intact; pointers wrap at least twice; count never exceeds 8.
REQ-039 Reset mid-operation: with count=5, pulse rst low asynchronously between edges -> count=0, valid_out=0, ready_out=1 immediately; after release, push 0x3C -> data_out=0x3C is the first word out.
REQ-040 Back-to-back with the arbiter tree: upstream drives valid_in=1 every cycle and consumer ready_in=1 -> one word per cycle after 1-cycle latency; count stays at or below 1.
